// File: rtl/seed_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : seed_hit_detector
//  Description : Tracks runs of consecutive diagonal matches coming out of a
//                comparator array. A run of WORD_LEN contiguous matches makes
//                one seed hit, which is queued in a small FIFO with a
//                valid/ready read port. Counts all hits and flags drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module seed_hit_detector #(
    parameter int LENGTH_COUNTER = 8,
    parameter int WORD_LEN       = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      com_clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic                      match,
    input  logic [LENGTH_COUNTER-1:0] query_id,
    input  logic [LENGTH_COUNTER-1:0] sub_id,
    output logic                      hit_valid,
    input  logic                      hit_ready,
    output logic [LENGTH_COUNTER-1:0] hit_query_id,
    output logic [LENGTH_COUNTER-1:0] hit_sub_id,
    output logic [7:0]                hit_count,
    output logic                      overflow
);

    localparam int                  c_ADDR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0]          c_WORD_LEN = 4'(WORD_LEN);
    localparam logic [c_ADDR_W:0]   c_DEPTH    = (c_ADDR_W + 1)'(FIFO_DEPTH);

    // Run tracking state
    logic [3:0]                r_run;
    logic [LENGTH_COUNTER-1:0] r_start_q;
    logic [LENGTH_COUNTER-1:0] r_start_s;
    logic [LENGTH_COUNTER-1:0] r_last_q;
    logic [LENGTH_COUNTER-1:0] r_last_s;

    // Hit FIFO state
    logic [2*LENGTH_COUNTER-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]         r_wr_ptr;
    logic [c_ADDR_W-1:0]         r_rd_ptr;
    logic [c_ADDR_W:0]           r_occ;
    logic [7:0]                  r_hit_count;
    logic                        r_overflow;

    logic [LENGTH_COUNTER-1:0]   w_next_q;
    logic [LENGTH_COUNTER-1:0]   w_next_s;
    logic                        w_contig;
    logic [3:0]                  w_run_next;
    logic                        w_hit;
    logic [LENGTH_COUNTER-1:0]   w_hit_q;
    logic [LENGTH_COUNTER-1:0]   w_hit_s;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_push;
    logic                        w_drop;
    logic [2*LENGTH_COUNTER-1:0] w_head;

    // Diagonal continuation test, hit generation and FIFO handshake decode.
    // Id increments wrap naturally at the id width, so wrap is contiguous.
    always_comb begin
        w_next_q   = r_last_q + LENGTH_COUNTER'(1);
        w_next_s   = r_last_s + LENGTH_COUNTER'(1);
        w_contig   = (r_run != 4'd0) && (query_id == w_next_q) && (sub_id == w_next_s);
        w_run_next = w_contig ? (r_run + 4'd1) : 4'd1;
        w_hit      = in_valid && match && (w_run_next == c_WORD_LEN);
        // A restarting run (WORD_LEN=1) reports the current ids as its start.
        w_hit_q    = w_contig ? r_start_q : query_id;
        w_hit_s    = w_contig ? r_start_s : sub_id;
        w_pop      = hit_valid && hit_ready;
        w_full     = (r_occ == c_DEPTH);
        // A full FIFO still accepts a hit when the head leaves on the same edge.
        w_push     = w_hit && (!w_full || w_pop);
        w_drop     = w_hit && w_full && !w_pop;
    end

    // Run length, run start and last-match registers.
    always_ff @(posedge com_clk) begin
        if (!reset_n) begin
            r_run     <= 4'd0;
            r_start_q <= '0;
            r_start_s <= '0;
            r_last_q  <= '0;
            r_last_s  <= '0;
        end else if (in_valid) begin
            if (!match) begin
                r_run <= 4'd0;
            end else begin
                // A completed run clears so consecutive hits never overlap.
                r_run    <= w_hit ? 4'd0 : w_run_next;
                r_last_q <= query_id;
                r_last_s <= sub_id;
                if (!w_contig) begin
                    r_start_q <= query_id;
                    r_start_s <= sub_id;
                end
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge com_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {w_hit_q, w_hit_s};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge com_clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + (c_ADDR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - (c_ADDR_W + 1)'(1);
            end
        end
    end

    // Saturating hit counter and sticky drop flag.
    always_ff @(posedge com_clk) begin
        if (!reset_n) begin
            r_hit_count <= 8'd0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_hit && (r_hit_count != 8'hFF)) begin
                r_hit_count <= r_hit_count + 8'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign hit_valid    = (r_occ != '0);
    assign hit_query_id = hit_valid ? w_head[2*LENGTH_COUNTER-1:LENGTH_COUNTER] : '0;
    assign hit_sub_id   = hit_valid ? w_head[LENGTH_COUNTER-1:0] : '0;
    assign hit_count    = r_hit_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seed_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seed_hit_detector
//  Description : Self-checking bench for seed_hit_detector. Two instances
//                (WORD_LEN=4 and WORD_LEN=1) share one stimulus stream; a
//                reference model predicts hits and queues them, a monitor
//                compares the DUT read port against the queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seed_hit_detector;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] s;
    } hit_t;

    logic            com_clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            match;
    logic [7:0]      query_id;
    logic [7:0]      sub_id;
    logic            hit_ready;
    logic [1:0]      hv;
    logic [1:0][7:0] hq;
    logic [1:0][7:0] hs;
    logic [1:0][7:0] hc;
    logic [1:0]      ov;

    always #5 com_clk = ~com_clk;

    seed_hit_detector #(.LENGTH_COUNTER(8), .WORD_LEN(4), .FIFO_DEPTH(DEPTH)) u_dut_w4 (
        .com_clk(com_clk), .reset_n(reset_n), .in_valid(in_valid), .match(match),
        .query_id(query_id), .sub_id(sub_id), .hit_valid(hv[0]), .hit_ready(hit_ready),
        .hit_query_id(hq[0]), .hit_sub_id(hs[0]), .hit_count(hc[0]), .overflow(ov[0])
    );

    seed_hit_detector #(.LENGTH_COUNTER(8), .WORD_LEN(1), .FIFO_DEPTH(DEPTH)) u_dut_w1 (
        .com_clk(com_clk), .reset_n(reset_n), .in_valid(in_valid), .match(match),
        .query_id(query_id), .sub_id(sub_id), .hit_valid(hv[1]), .hit_ready(hit_ready),
        .hit_query_id(hq[1]), .hit_sub_id(hs[1]), .hit_count(hc[1]), .overflow(ov[1])
    );

    // Reference model state, one slot per instance
    int   wlen [2] = '{4, 1};
    int   rlen [2];
    int   sq [2], ss [2], lq [2], ls [2];
    int   occ [2], cnt [2];
    bit   ovf [2];
    int   exp_occ [2], exp_cnt [2];
    bit   exp_ovf [2];
    hit_t sb0 [$];
    hit_t sb1 [$];

    int   nchecks = 0;
    int   nfail   = 0;
    bit   chk_en  = 1'b0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s inst%0d actual=%0d expected=%0d t=%0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int sb_size(input int k);
        return (k == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic sb_push(input int k, input hit_t h);
        if (k == 0) sb0.push_back(h); else sb1.push_back(h);
    endtask

    task automatic sb_pop(input int k, output hit_t h);
        if (k == 0) h = sb0.pop_front(); else h = sb1.pop_front();
    endtask

    task automatic sb_peek(input int k, output hit_t h);
        if (k == 0) h = sb0[0]; else h = sb1[0];
    endtask

    // Predict the effect of the coming edge from the inputs just applied.
    task automatic model_step(input int k);
        bit   pop;
        bit   hit;
        bit   contig;
        hit_t h;
        if (!reset_n) begin
            rlen[k] = 0; sq[k] = 0; ss[k] = 0; lq[k] = 0; ls[k] = 0;
            occ[k] = 0; cnt[k] = 0; ovf[k] = 1'b0;
            if (k == 0) sb0.delete(); else sb1.delete();
        end else begin
            pop = (occ[k] > 0) && hit_ready;
            hit = 1'b0;
            if (in_valid) begin
                if (!match) begin
                    rlen[k] = 0;
                end else begin
                    contig = (rlen[k] > 0) && (int'(query_id) == (lq[k] + 1) % 256)
                             && (int'(sub_id) == (ls[k] + 1) % 256);
                    if (contig) begin
                        rlen[k]++;
                    end else begin
                        rlen[k] = 1; sq[k] = query_id; ss[k] = sub_id;
                    end
                    lq[k] = query_id; ls[k] = sub_id;
                    if (rlen[k] == wlen[k]) begin
                        hit = 1'b1; rlen[k] = 0;
                    end
                end
            end
            if (hit) begin
                if (cnt[k] < 255) cnt[k]++;
                if (occ[k] < DEPTH || pop) begin
                    h.q = 8'(sq[k]); h.s = 8'(ss[k]);
                    sb_push(k, h);
                    occ[k]++;
                end else begin
                    ovf[k] = 1'b1;
                end
            end
            if (pop) occ[k]--;
        end
    endtask

    // One clock of stimulus; the snapshot is the state the DUT shows this cycle.
    task automatic cycle(input bit v, input bit m, input logic [7:0] q, input logic [7:0] s,
                         input bit rdy, input bit rst_n);
        @(posedge com_clk);
        #1;
        reset_n = rst_n; in_valid = v; match = m; query_id = q; sub_id = s; hit_ready = rdy;
        for (int k = 0; k < 2; k++) begin
            exp_occ[k] = occ[k]; exp_cnt[k] = cnt[k]; exp_ovf[k] = ovf[k];
            model_step(k);
        end
    endtask

    task automatic mt(input logic [7:0] q, input logic [7:0] s, input bit rdy);
        cycle(1'b1, 1'b1, q, s, rdy, 1'b1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 8'd0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic check_inst(input int k);
        hit_t h;
        chk("hit_valid", k, int'(hv[k]), int'(exp_occ[k] != 0));
        chk("hit_count", k, int'(hc[k]), exp_cnt[k]);
        chk("overflow", k, int'(ov[k]), int'(exp_ovf[k]));
        if (hv[k]) begin
            if (sb_size(k) == 0) begin
                chk("sb_nonempty", k, 0, 1);
            end else begin
                sb_peek(k, h);
                chk("hit_query_id", k, int'(hq[k]), int'(h.q));
                chk("hit_sub_id", k, int'(hs[k]), int'(h.s));
                if (hit_ready) sb_pop(k, h);
            end
        end else begin
            chk("empty_query_id", k, int'(hq[k]), 0);
            chk("empty_sub_id", k, int'(hs[k]), 0);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge com_clk) begin
        if (chk_en && reset_n) begin
            for (int k = 0; k < 2; k++) check_inst(k);
        end
    end

    initial begin
        logic [7:0] rq;
        logic [7:0] rs;
        bit         rv, rm, rr, rn;
        reset_n = 1'b0; in_valid = 1'b0; match = 1'b0;
        query_id = 8'd0; sub_id = 8'd0; hit_ready = 1'b1;
        do_reset();
        do_reset();
        chk_en = 1'b1;

        // Basic run and wrap-around run
        mt(8'd10, 8'd20, 1); mt(8'd11, 8'd21, 1); mt(8'd12, 8'd22, 1); mt(8'd13, 8'd23, 1);
        idle(3, 1);
        mt(8'd254, 8'd7, 1); mt(8'd255, 8'd8, 1); mt(8'd0, 8'd9, 1); mt(8'd1, 8'd10, 1);
        idle(2, 1);

        // Mismatch breaks a run; off-diagonal match restarts it
        mt(8'd5, 8'd5, 1); mt(8'd6, 8'd6, 1);
        cycle(1'b1, 1'b0, 8'd7, 8'd7, 1'b1, 1'b1);
        mt(8'd7, 8'd7, 1); mt(8'd8, 8'd8, 1); mt(8'd9, 8'd9, 1); mt(8'd10, 8'd10, 1);
        idle(1, 1);
        mt(8'd5, 8'd5, 1); mt(8'd6, 8'd9, 1); mt(8'd7, 8'd10, 1); mt(8'd8, 8'd11, 1); mt(8'd9, 8'd12, 1);
        idle(2, 1);

        // Back-pressure: six hits into a four-entry FIFO, then drain
        do_reset();
        for (int i = 0; i < 6; i++) mt(8'(i * 3), 8'(i * 5 + 1), 0);
        idle(2, 0);
        idle(6, 1);

        // Full FIFO with simultaneous pop and push: nothing dropped
        do_reset();
        for (int i = 0; i < 4; i++) mt(8'(i * 7 + 2), 8'(i * 2), 0);
        idle(1, 0);
        mt(8'd99, 8'd77, 1);
        idle(6, 1);

        // Reset discards a partial run
        do_reset();
        mt(8'd20, 8'd30, 1); mt(8'd21, 8'd31, 1); mt(8'd22, 8'd32, 1);
        do_reset();
        mt(8'd40, 8'd50, 1); mt(8'd41, 8'd51, 1); mt(8'd42, 8'd52, 1); mt(8'd43, 8'd53, 1);
        idle(3, 1);

        // Randomized traffic, mostly diagonal so runs complete often
        rq = 8'($urandom); rs = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom % 500) != 0;
            rv = ($urandom % 4) != 0;
            rm = ($urandom % 8) != 0;
            rr = ($urandom % 2) != 0;
            if (($urandom % 4) != 0) begin
                rq = rq + 8'd1; rs = rs + 8'd1;
            end else begin
                rq = 8'($urandom); rs = 8'($urandom);
            end
            cycle(rv, rm, rq, rs, rr, rn);
        end
        idle(8, 1);

        @(posedge com_clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seed_hit_detector.md
SEED_HIT_DETECTOR -- requirements
Module: seed_hit_detector

Interface
REQ-001 Parameter LENGTH_COUNTER, default 8: width of query/subject position ids.
REQ-002 Parameter WORD_LEN, default 4: consecutive diagonal matches that form one seed hit; legal range 1..15.
REQ-003 Parameter FIFO_DEPTH, default 4: hit FIFO entries; power of two, at least 2.
REQ-004 com_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset, sampled on rising com_clk.
REQ-006 in_valid  input  1  comparator result valid this cycle (driven from the array stage's sub_enable, delayed one cycle).
REQ-007 match  input  1  comparator match flag.
REQ-008 query_id  input  LENGTH_COUNTER  query position of the compared character.
REQ-009 sub_id  input  LENGTH_COUNTER  subject position of the compared character.
REQ-010 hit_valid  output  1  FIFO non-empty; head hit presented.
REQ-011 hit_ready  input  1  consumer accepts head hit when high together with hit_valid.
REQ-012 hit_query_id  output  LENGTH_COUNTER  query id of the first match of the hit run.
REQ-013 hit_sub_id  output  LENGTH_COUNTER  subject id of the first match of the hit run.
REQ-014 hit_count  output  8  total hits detected, dropped hits included; saturates at 255.
REQ-015 overflow  output  1  sticky flag: at least one hit was dropped because the FIFO was full.

Function
REQ-016 The block SHALL hold run length, run start ids and last-match ids; with in_valid=0 it SHALL hold all of them unchanged.
REQ-017 With in_valid=1 and match=0, run length SHALL clear to 0.
REQ-018 With in_valid=1, match=1, run>0, query_id==last_q+1 and sub_id==last_s+1 (modulo 2^LENGTH_COUNTER), run SHALL increment.
REQ-019 With in_valid=1, match=1 and the REQ-018 condition false (including run==0), run SHALL restart at 1 with start ids = current ids.
REQ-020 On every in_valid=1, match=1 cycle, last_q/last_s SHALL load query_id/sub_id.
REQ-021 Id wrap from 2^LENGTH_COUNTER-1 to 0 SHALL count as contiguous.
REQ-022 When an update makes run equal to WORD_LEN, the block SHALL generate one hit {start_q, start_s} and clear run to 0; hits do not overlap.
REQ-023 With WORD_LEN=1, every accepted match SHALL produce a hit with its own ids.
REQ-024 A generated hit SHALL be written to the FIFO on the same edge; hit_valid SHALL be high the cycle after that edge (latency 1 from the accepting edge).
REQ-025 Pop SHALL occur on an edge with hit_valid=1 and hit_ready=1; hit_query_id/hit_sub_id SHALL stay stable while hit_valid=1 and hit_ready=0.
REQ-026 FIFO order SHALL be first-in, first-out.
REQ-027 A hit arriving when the FIFO is full and a pop happens on the same edge SHALL be stored.
REQ-028 A hit arriving when the FIFO is full without a pop SHALL be dropped and overflow SHALL be set.
REQ-029 hit_count SHALL increment on every generated hit, stored or dropped, and hold at 255.
REQ-030 hit_query_id/hit_sub_id SHALL read 0 while the FIFO is empty.

Reset
REQ-031 With reset_n=0 at an edge, the block SHALL clear run, start ids, last ids, FIFO pointers and occupancy, hit_count and overflow to 0, and drive hit_valid=0. Reset SHALL take priority over all inputs, including a hit or pop on the same edge.
REQ-032 Reset in the middle of a run SHALL discard the partial run; the first match after reset SHALL start a new run.

Verification
REQ-033 WORD_LEN=4, hit_ready=1; matches at (q,s)=(10,20),(11,21),(12,22),(13,23) on consecutive valid cycles -> one hit {10,20}, hit_valid high exactly one cycle, hit_count=1.
REQ-034 Matches at (254,7),(255,8),(0,9),(1,10) -> hit {254,7}, covering wrap.
REQ-035 Matches at (5,5),(6,6), then a mismatch, then (7,7),(8,8),(9,9),(10,10) -> single hit {7,7}; a non-diagonal (6,9) after (5,5) restarts the run at {6,9}.
REQ-036 hit_ready=0, WORD_LEN=1, 6 matches -> 4 hits held in order, overflow=1, hit_count=6; then hit_ready=1 -> the first 4 hits drain in order and hit_valid drops.
REQ-037 FIFO full, hit_ready=1 and a new hit on the same edge -> no drop, overflow stays 0.
REQ-038 reset_n=0 after 3 of 4 run matches, then 4 fresh matches -> only the post-reset hit appears; hit_count=1.
